// File: rtl/xnor_cmp_pipe.sv
// Two-stage valid/ready pipelined XNOR/XOR comparator with equality flag and match count.
// Build with XNOR_CMP_POPCNT_EN defined to include the match_cnt popcount; otherwise match_cnt is 0.
module xnor_cmp_pipe #(
  parameter  int WIDTH = 8,
  localparam int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             xor_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             eq,
  output logic [CNTW-1:0]  match_cnt
);

  logic             s1_valid;
  logic [WIDTH-1:0] v1;
  logic             mode1;
  logic             s2_valid;
  logic             s1_adv;
  logic             s2_adv;
  logic             in_fire;
  logic             s2_load;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign in_fire   = in_valid && s1_adv;
  // Data flops only move on a real transfer so results stay put while empty.
  assign s2_load   = s2_adv && s1_valid;
  assign out_valid = s2_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      v1       <= '0;
      mode1    <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      v1       <= a ~^ b;
      mode1    <= xor_mode;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      y        <= '0;
      eq       <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s2_load) begin
        y  <= mode1 ? ~v1 : v1;
        eq <= &v1;
      end
    end
  end

`ifdef XNOR_CMP_POPCNT_EN
  logic [CNTW-1:0] pop1;

  always_comb begin
    pop1 = '0;
    for (int i = 0; i < WIDTH; i++) pop1 = pop1 + CNTW'(v1[i]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) match_cnt <= '0;
    else if (s2_load) match_cnt <= pop1;
  end
`else
  assign match_cnt = '0;
`endif

endmodule
